lcd_bus_driver: RTL and testbench
=================================

// Module: lcd_bus_driver
// PURPOSE
//  Timing-accurate HD44780 write-bus driver. Sits between the command/character
//  sequencer and the LCD pins. Takes one byte at a time (rs + data) over a
//  valid/ready handshake and generates setup / E-pulse / hold / execution-wait
//  timing. Enforces the power-up delay after reset. Write-only; busy flag is
//  never read.
// PARAMETERS
//  T_POWERUP   1500000  cycles after reset before first accept (15 ms @100 MHz)
//  T_SETUP     4        cycles rs/dout stable before en rises (>=1)
//  T_PULSE     25       cycles en held high (>=1)
//  T_HOLD      2        cycles rs/dout held after en falls (>=1)
//  T_EXEC      4000     post-write wait, normal cmd/data (40 us) (>=1)
//  T_EXEC_LONG 164000   post-write wait, clear/home (1.64 ms) (>=1)
//  CNT_W       21       delay counter width; must hold max(all T_*)
// PORTS
//  clk       in   1  system clock, rising edge
//  rst       in   1  synchronous, active-high reset
//  in_valid  in   1  upstream byte available
//  in_rs     in   1  0 = command, 1 = character data
//  in_data   in   8  byte to write
//  in_ready  out  1  driver can accept; transfer when in_valid && in_ready
//  busy      out  1  1 whenever state != IDLE
//  rs        out  1  LCD register select
//  rw        out  1  LCD read/write; constant 0
//  en        out  1  LCD enable strobe
//  dout      out  8  LCD data bus D7..D0
// BEHAVIOUR
//  Clock and reset: single clock domain; reset is synchronous and active-high.
//  - All outputs registered except in_ready / busy (decoded from state).
//  - Reset (sampled at clk edge): state=POWERUP, counter=T_POWERUP-1; rs=0,
//    rw=0, en=0, dout=8'h00; in_ready=0, busy=1. Reset overrides all, any state.
//  - States: POWERUP -> IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE.
//  - Each timed state lasts exactly its T_* cycles: counter loads T-1 on entry,
//    decrements, exits when it reaches 0.
//  - IDLE: in_ready=1. On accept edge: latch in_rs->rs, in_data->dout,
//    classify long = (~in_rs && in_data[7:2]==0 && in_data[1:0]!=0), i.e.
//    cmds 0x01..0x03; go to SETUP. in_ready is 0 from the next cycle.
//  - SETUP: en=0, rs/dout driven. PULSE: en=1. HOLD: en=0, rs/dout unchanged.
//  - WAIT: T_EXEC_LONG if long else T_EXEC. rs/dout keep last value.
//  - in_data/in_rs changes after accept are ignored. in_valid outside IDLE is
//    ignored; the upstream holds it until accepted.
//  - Occupancy per byte: 1 (accept) + T_SETUP + T_PULSE + T_HOLD + T_EXEC[_LONG].
//  - Mid-operation reset: en=0 and in_ready=0 from the next cycle; the full
//    T_POWERUP wait repeats. The in-flight byte is dropped, not replayed.
//  - Counter never wraps: loads only on state entry, saturates at 0.
// STRUCTURE
//  - lcd_pkg: state enum (POWERUP, IDLE, SETUP, PULSE, HOLD, WAIT);
//    CMD_CLEAR=8'h01, CMD_HOME=8'h02; default timing constants for 100 MHz.
//  - Sub-module lcd_delay_counter: CNT_W-bit down counter, inputs load/value,
//    output done (count==0). Reused by the upstream sequencer.
//  - Top: FSM, output registers, long-command decode.
// TESTING (bench params: T_POWERUP=10, T_SETUP=2, T_PULSE=3, T_HOLD=1,
//          T_EXEC=5, T_EXEC_LONG=20)
//  1. Release rst, hold in_valid=1 -> in_ready=0 for exactly 10 cycles, then
//     1; en stays 0 throughout.
//  2. Accept rs=1,data=8'h76 -> rs=1, dout=8'h76 next cycle; en=1 on cycles
//     3..5 after accept; next in_ready 12 cycles after accept.
//  3. Accept rs=0,data=8'h01 -> WAIT lasts 20 cycles (next accept 27 cycles
//     after). rs=0,data=8'h80 -> 5 cycles. rs=1,data=8'h01 -> 5 cycles.
//  4. Back-to-back: in_valid held high, bytes 8'h38,8'h0E -> exactly two accepts
//     12 cycles apart; dout changes only on the cycle after each accept.
//  5. Change in_data to 8'hFF during PULSE -> dout keeps latched value.
//  6. Assert rst during PULSE -> en=0, dout=8'h00 next cycle; POWERUP re-run
//     (10 cycles) before in_ready=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-bus driver.
// Default timings assume a 100 MHz clock.
package lcd_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int DEF_T_POWERUP   = 1500000;
    localparam int DEF_T_SETUP     = 4;
    localparam int DEF_T_PULSE     = 25;
    localparam int DEF_T_HOLD      = 2;
    localparam int DEF_T_EXEC      = 4000;
    localparam int DEF_T_EXEC_LONG = 164000;
    localparam int DEF_CNT_W       = 21;

    // Clear and return-home (0x01..0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data >= CMD_CLEAR) && (data <= (CMD_CLEAR | CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// Byte handshake from the sequencer plus the LCD pin group.
// master = sequencer side, slave = the bus driver.
interface lcd_bus_driver_if;

    logic       in_valid;
    logic       in_rs;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] dout;

    modport master (
        output in_valid, in_rs, in_data,
        input  in_ready, busy, rs, rw, en, dout
    );

    modport slave (
        input  in_valid, in_rs, in_data,
        output in_ready, busy, rs, rw, en, dout
    );

endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down counter that saturates at zero; done while count is zero.
module lcd_delay_counter #(
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus driver: power-up delay, then per-byte
// setup / enable pulse / hold / execution wait sequencing.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int T_POWERUP   = DEF_T_POWERUP,
    parameter int T_SETUP     = DEF_T_SETUP,
    parameter int T_PULSE     = DEF_T_PULSE,
    parameter int T_HOLD      = DEF_T_HOLD,
    parameter int T_EXEC      = DEF_T_EXEC,
    parameter int T_EXEC_LONG = DEF_T_EXEC_LONG,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    lcd_bus_driver_if.slave  bus
);

    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE   = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC    = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG    = CNT_W'(T_EXEC_LONG - 1);

    lcd_state_t       r_state;
    lcd_state_t       w_state_next;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_value;
    logic             w_cnt_done;

    logic             r_rs;
    logic             r_en;
    logic             r_long;
    logic [7:0]       r_dout;
    logic             w_rs_next;
    logic             w_en_next;
    logic             w_long_next;
    logic [7:0]       w_dout_next;
    logic             w_in_ready;
    logic             w_accept;

    lcd_delay_counter #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk     (clk),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .o_done  (w_cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= POWERUP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The counter is loaded only on entry to a timed state; reset reloads the power-up wait.
    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_value  = LD_POWERUP;
        case (r_state)
            POWERUP: if (w_cnt_done) w_state_next = IDLE;
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = SETUP;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = LD_SETUP;
                end
            end
            SETUP: begin
                if (w_cnt_done) begin
                    w_state_next = PULSE;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = LD_PULSE;
                end
            end
            PULSE: begin
                if (w_cnt_done) begin
                    w_state_next = HOLD;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = LD_HOLD;
                end
            end
            HOLD: begin
                if (w_cnt_done) begin
                    w_state_next = WAIT;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = r_long ? LD_LONG : LD_EXEC;
                end
            end
            WAIT: if (w_cnt_done) w_state_next = IDLE;
            default: begin
                w_state_next = POWERUP;
                w_cnt_load   = 1'b1;
            end
        endcase
        if (rst) begin
            w_state_next = POWERUP;
            w_cnt_load   = 1'b1;
            w_cnt_value  = LD_POWERUP;
        end
    end

    always_comb begin
        w_in_ready  = (r_state == IDLE);
        w_accept    = w_in_ready && bus.in_valid;
        w_rs_next   = w_accept ? bus.in_rs : r_rs;
        w_dout_next = w_accept ? bus.in_data : r_dout;
        w_long_next = w_accept ? is_long_cmd(bus.in_rs, bus.in_data) : r_long;
        w_en_next   = (w_state_next == PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs   <= 1'b0;
            r_en   <= 1'b0;
            r_long <= 1'b0;
            r_dout <= 8'h00;
        end else begin
            r_rs   <= w_rs_next;
            r_en   <= w_en_next;
            r_long <= w_long_next;
            r_dout <= w_dout_next;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = !w_in_ready;
    assign bus.rs       = r_rs;
    assign bus.rw       = 1'b0;
    assign bus.en       = r_en;
    assign bus.dout     = r_dout;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with shortened timings and a byte scoreboard.
module tb_lcd_bus_driver;

    typedef struct {
        logic       rs;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lcd_bus_driver_if bus ();

    lcd_bus_driver #(
        .T_POWERUP   (10),
        .T_SETUP     (2),
        .T_PULSE     (3),
        .T_HOLD      (1),
        .T_EXEC      (5),
        .T_EXEC_LONG (20),
        .CNT_W       (21)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at the sample just after the last reset edge.
    task automatic powerup_check();
        int zeros = 0;
        int en_hi = 0;
        bit seen  = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.en) en_hi++;
            if (bus.in_ready) seen = 1'b1;
            else begin
                zeros++;
                step();
            end
        end
        check("powerup_ready", 32'(seen), 1);
        check("powerup_len", zeros, 10);
        check("powerup_en", en_hi, 0);
        $display("[TB] powerup: in_ready low for %0d cycles", zeros);
    endtask

    task automatic send(input logic rs, input logic [7:0] data, input int occ,
                        input bit corrupt, output int waited);
        int   k     = 1;
        int   en_hi = 0;
        int   dchg  = 0;
        bit   done  = 1'b0;
        logic prev_en;
        exp_t e;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_rs    = rs;
        bus.in_data  = data;
        while (!bus.in_ready && waited < 100) begin
            step();
            waited++;
        end
        check("accept_ready", bus.in_ready, 1);
        sb.push_back('{rs, data});
        step();
        check("latch_rs", bus.rs, rs);
        check("latch_dout", bus.dout, data);
        check("ready_drop", bus.in_ready, 0);
        prev_en = bus.en;
        if (bus.en) en_hi++;
        while (!done && k < 100) begin
            step();
            k++;
            if (bus.dout !== data || bus.rs !== rs) dchg++;
            if (bus.en) begin
                en_hi++;
                if (!prev_en) begin
                    check("en_rise_cycle", k, 3);
                    check("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("sb_rs", bus.rs, e.rs);
                        check("sb_dout", bus.dout, e.data);
                    end
                end
            end
            prev_en = bus.en;
            if (bus.in_ready) done = 1'b1;
            if (corrupt && k == 3) begin
                bus.in_data = 8'hFF;
                bus.in_rs   = ~rs;
            end
        end
        check("occupancy", k, occ);
        check("en_cycles", en_hi, 3);
        check("bus_stable", dchg, 0);
        check("busy_idle", bus.busy, 0);
        $display("[TB] byte rs=%0d data=%02h wait=%0d occupancy=%0d en_cycles=%0d",
                 rs, data, waited, k, en_hi);
    endtask

    initial begin
        int w;
        bus.in_valid = 1'b1;
        bus.in_rs    = 1'b1;
        bus.in_data  = 8'h76;
        rst          = 1'b1;
        repeat (3) step();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_en", bus.en, 0);
        check("rst_rs", bus.rs, 0);
        check("rst_rw", bus.rw, 0);
        check("rst_dout", bus.dout, 8'h00);
        powerup_check();

        send(1'b1, 8'h76, 12, 1'b0, w);
        check("first_wait", w, 0);
        send(1'b0, 8'h01, 27, 1'b0, w);
        send(1'b0, 8'h80, 12, 1'b0, w);
        send(1'b1, 8'h01, 12, 1'b0, w);
        send(1'b0, 8'h03, 27, 1'b0, w);
        send(1'b0, 8'h38, 12, 1'b0, w);
        send(1'b0, 8'h0E, 12, 1'b0, w);
        check("b2b_wait", w, 0);
        send(1'b1, 8'h48, 12, 1'b1, w);

        // Reset in the middle of the enable pulse; this byte is dropped.
        bus.in_valid = 1'b1;
        bus.in_rs    = 1'b1;
        bus.in_data  = 8'h41;
        for (int i = 0; i < 100 && !bus.in_ready; i++) step();
        step();
        step();
        step();
        check("pulse_en", bus.en, 1);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        check("midrst_en", bus.en, 0);
        check("midrst_dout", bus.dout, 8'h00);
        check("midrst_rs", bus.rs, 0);
        check("midrst_ready", bus.in_ready, 0);
        check("midrst_busy", bus.busy, 1);
        $display("[TB] mid-pulse reset applied");
        powerup_check();

        send(1'b0, 8'h06, 12, 1'b0, w);
        bus.in_valid = 1'b0;
        step();
        check("idle_after_drop", bus.in_ready, 1);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
